video_mem_seq: RTL
==================

Name: video_mem_seq

Overview:
Memory sequencer directly upstream of the video generator's dot generator. It time-slices one shared SRAM between video fetches and CPU accesses within each 8-pixel character slot. It generates video_ram_strobe and video_rom_strobe, translates the 12-bit video address into SRAM space, and returns fetched bytes on video_data. CPU accesses use the remaining slot phases with a req/ack handshake.

Parameters:
ADDR_WIDTH, 17, SRAM address width
VRAM_BASE, 17'h08000, SRAM base of 2KB video RAM (video_addr[11]=0)
CHROM_BASE, 17'h10000, SRAM base of 2KB character ROM (video_addr[11]=1)

Ports:
pixel_clk  in  1  pixel clock (40 col = 8 MHz); sole clock
reset  in  1  synchronous, active-low reset
char_sync  in  1  character clock pulse (high on last pixel of a character); next cycle is phase 0
video_addr  in  12  address from dot generator; [11] selects ROM
video_data  out  8  fetched byte to dot generator data input
video_ram_strobe  out  1  video RAM fetch strobe
video_rom_strobe  out  1  character ROM fetch strobe
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write
cpu_addr  in  ADDR_WIDTH  CPU SRAM address
cpu_wdata  in  8  write data
cpu_rdata  out  8  read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
mem_addr  out  ADDR_WIDTH  SRAM address
mem_oe_n  out  1  SRAM output enable, active low
mem_we_n  out  1  SRAM write enable, active low
mem_wdata  out  8  SRAM write data
mem_wdata_oe  out  1  drive enable for SRAM data bus
mem_rdata  in  8  SRAM read data
resync_err  out  1  sticky: char_sync seen at phase != 7

Behaviour:
- Reset (reset=0 at pixel_clk edge): phase=0, locked=0, outputs at reset values: strobes 0, video_data 0, cpu_rdata 0, cpu_ack 0, mem_addr 0, mem_oe_n 1, mem_we_n 1, mem_wdata 0, mem_wdata_oe 0, resync_err 0.
- Phase counter, 3 bits: char_sync=1 -> phase<=0 and locked<=1; otherwise phase<=phase+1, wrapping 7->0. While locked=0, memory stays idle (no strobes, no CPU service).
- All outputs are registered. Slot schedule by phase (locked only):
  - ph0: video_ram_strobe=1.
  - ph1: strobe held 1. mem_addr = VRAM_BASE | video_addr[10:0] (or CHROM_BASE if [11]=1), sampled at end of ph0. mem_oe_n=0.
  - ph2: video_ram_strobe=0. video_data = mem_rdata, captured at end of ph1. video_data is stable on the strobe falling edge and stays valid through ph4.
  - ph3: guard/idle, all strobes low. This lets the dot generator latch the char code before the ROM address is formed.
  - ph4: video_rom_strobe=1.
  - ph5: strobe held 1. ROM address sampled at end of ph4, same mapping. mem_oe_n=0.
  - ph6: video_rom_strobe=0. video_data = mem_rdata captured at end of ph5.
  - ph6-ph7, CPU slot: cpu_req is sampled at end of ph5.
    - Read: mem_addr=cpu_addr and mem_oe_n=0 in ph6. cpu_rdata captured at end of ph6. cpu_ack=1 during ph7.
    - Write: mem_addr, mem_wdata and mem_wdata_oe in ph6-ph7. mem_we_n=0 in ph7 only. cpu_ack=1 during ph7.
  - No request sampled -> SRAM idle, no ack.
- Handshake:
  - cpu_req must stay high until cpu_ack.
  - Worst-case latency from req to ack is 10 cycles.
  - A request dropped before sampling is ignored.
  - cpu_req held high after ack starts a new access in the next slot.
- mem_oe_n and mem_we_n are never both 0. mem_wdata_oe=1 only during a write slot.
- Video address translation: offset = video_addr[10:0] zero-extended; base OR offset. Bases must be 2KB-aligned.
- Resync mid-slot (char_sync at phase != 7):
  - Phase forced to 0 and any active strobe dropped.
  - In-flight CPU access aborted without ack; it retries in the next slot.
  - resync_err set; cleared only by reset.
- char_sync coincident with reset=0: reset wins.
- char_sync asserted on consecutive cycles: phase stays 0, ph0 outputs repeat, no CPU service.

Decomposition:
- Shared package video_pkg: phase localparams PH_RAM_STB=0, PH_RAM_ADDR=1, PH_RAM_DATA=2, PH_GUARD=3, PH_ROM_STB=4, PH_ROM_ADDR=5, PH_CPU_ADDR=6, PH_CPU_DONE=7; the default base addresses.
- One natural sub-module, video_addr_map: combinational 12-bit to ADDR_WIDTH translation; it is reused by the CPU-side decoder.

Test Plan:
- Reset held low 4 cycles, then char_sync every 8 cycles -> all outputs at reset values during reset; first video_ram_strobe rises 1 cycle after the first char_sync.
- video_addr=12'h005, SRAM[0x08005]=0x41, then video_addr=12'h80A, SRAM[0x1000A]=0x3C:
  - mem_addr=0x08005 in ph1; video_data=0x41 at ph2.
  - mem_addr=0x1000A in ph5; video_data=0x3C at ph6.
- CPU read at 0x00123=0x5A raised at ph2 -> mem_addr=0x00123 in ph6; cpu_rdata=0x5A with cpu_ack in ph7; no ack elsewhere.
- CPU write 0x77 to 0x08010 raised at ph6 (after sampling) -> serviced next slot; mem_we_n low only in ph7; SRAM[0x08010]=0x77; strobes unaffected.
- char_sync injected at ph6 during a CPU write -> mem_we_n stays 1, no ack, resync_err=1; write completes in the following slot.
- Reset asserted during ph5 -> outputs at reset values next cycle; no strobe until a new char_sync.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: phase numbering and default SRAM bases for the video memory sequencer
package video_pkg;
  localparam logic [2:0] PH_RAM_STB  = 3'd0;
  localparam logic [2:0] PH_RAM_ADDR = 3'd1;
  localparam logic [2:0] PH_RAM_DATA = 3'd2;
  localparam logic [2:0] PH_GUARD    = 3'd3;
  localparam logic [2:0] PH_ROM_STB  = 3'd4;
  localparam logic [2:0] PH_ROM_ADDR = 3'd5;
  localparam logic [2:0] PH_CPU_ADDR = 3'd6;
  localparam logic [2:0] PH_CPU_DONE = 3'd7;
  localparam logic [16:0] VRAM_BASE_DEF  = 17'h08000;
  localparam logic [16:0] CHROM_BASE_DEF = 17'h10000;
endpackage

// File: rtl/video_addr_map.sv
// video_addr_map: maps a 12-bit video address onto the 2KB-aligned VRAM or character ROM window
module video_addr_map import video_pkg::*; #(
  parameter int ADDR_WIDTH = 17,
  parameter logic [ADDR_WIDTH-1:0] VRAM_BASE = ADDR_WIDTH'(VRAM_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] CHROM_BASE = ADDR_WIDTH'(CHROM_BASE_DEF)
) (
  input  logic [11:0]           addr,
  output logic [ADDR_WIDTH-1:0] mapped
);
  always_comb mapped = (addr[11] ? CHROM_BASE : VRAM_BASE) | ADDR_WIDTH'(addr[10:0]);
endmodule

// File: rtl/video_mem_seq.sv
// video_mem_seq: time-slices one SRAM between video fetches and CPU accesses per 8-pixel character slot
module video_mem_seq import video_pkg::*; #(
  parameter int ADDR_WIDTH = 17,
  parameter logic [ADDR_WIDTH-1:0] VRAM_BASE = ADDR_WIDTH'(VRAM_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] CHROM_BASE = ADDR_WIDTH'(CHROM_BASE_DEF)
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  input  logic                  char_sync,
  input  logic [11:0]           video_addr,
  output logic [7:0]            video_data,
  output logic                  video_ram_strobe,
  output logic                  video_rom_strobe,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_oe_n,
  output logic                  mem_we_n,
  output logic [7:0]            mem_wdata,
  output logic                  mem_wdata_oe,
  input  logic [7:0]            mem_rdata,
  output logic                  resync_err
);
  logic [2:0] phase, nph;
  logic locked, lk, cpu_act, cpu_wr;
  logic [ADDR_WIDTH-1:0] vaddr;
  video_addr_map #(.ADDR_WIDTH(ADDR_WIDTH), .VRAM_BASE(VRAM_BASE), .CHROM_BASE(CHROM_BASE)) u_map (
    .addr(video_addr),
    .mapped(vaddr)
  );
  // Outputs are registered, so each is computed from the phase the next cycle will be in.
  always_comb begin
    nph = char_sync ? PH_RAM_STB : phase + 3'd1;
    lk = locked | char_sync;
  end
  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      phase <= PH_RAM_STB;
      locked <= 1'b0;
      cpu_act <= 1'b0;
      cpu_wr <= 1'b0;
      video_data <= '0;
      video_ram_strobe <= 1'b0;
      video_rom_strobe <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack <= 1'b0;
      mem_addr <= '0;
      mem_oe_n <= 1'b1;
      mem_we_n <= 1'b1;
      mem_wdata <= '0;
      mem_wdata_oe <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      phase <= nph;
      locked <= lk;
      if (locked && char_sync && phase != PH_CPU_DONE) resync_err <= 1'b1;
      video_ram_strobe <= lk && (nph == PH_RAM_STB || nph == PH_RAM_ADDR);
      video_rom_strobe <= lk && (nph == PH_ROM_STB || nph == PH_ROM_ADDR);
      mem_addr <= '0;
      mem_oe_n <= 1'b1;
      mem_we_n <= 1'b1;
      mem_wdata <= '0;
      mem_wdata_oe <= 1'b0;
      cpu_ack <= 1'b0;
      if (lk && (nph == PH_RAM_ADDR || nph == PH_ROM_ADDR)) begin
        mem_addr <= vaddr;
        mem_oe_n <= 1'b0;
      end
      if (lk && (nph == PH_RAM_DATA || nph == PH_CPU_ADDR)) video_data <= mem_rdata;
      if (lk && nph == PH_CPU_ADDR) begin
        cpu_act <= cpu_req;
        cpu_wr <= cpu_we;
        if (cpu_req) begin
          mem_addr <= cpu_addr;
          mem_oe_n <= cpu_we;
          mem_wdata <= cpu_we ? cpu_wdata : 8'h00;
          mem_wdata_oe <= cpu_we;
        end
      end
      // A resync leaves nph at 0, so an in-flight access never reaches its ack.
      if (lk && nph == PH_CPU_DONE && cpu_act) begin
        cpu_ack <= 1'b1;
        if (cpu_wr) begin
          mem_addr <= mem_addr;
          mem_wdata <= mem_wdata;
          mem_wdata_oe <= 1'b1;
          mem_we_n <= 1'b0;
        end else cpu_rdata <= mem_rdata;
      end
    end
  end
endmodule
